trachtenberg_feeder: RTL and testbench
======================================

// Module: trachtenberg_feeder
// PURPOSE
//  Upstream sequencer for the 5x5 Trachtenberg multiplier core: accepts operand pairs on a valid/ready stream
//  and buffers them in a small FIFO. Issues one multiply at a time via a one-cycle start pulse, waits a fixed
//  settle time for the carry chain to resolve, then captures the product and presents it on a valid/ready
//  result stream. Sits between the operand source and the multiplier core; owns all flow control for the core.
// PARAMETERS
//  DEPTH   4   operand FIFO entries (power of 2, >=2)
//  SETTLE  12  cycles from the first WAIT cycle to product capture (core needs >=11; must be >=1)
// PORTS
//  iclk       in   1   clock, all logic on rising edge
//  irst       in   1   reset, asynchronous, active-high
//  in_a       in   5   multiplicand
//  in_b       in   5   multiplier
//  in_valid   in   1   operand pair valid
//  in_ready   out  1   FIFO can accept (count < DEPTH)
//  mul_a      out  5   operand A to core (registered)
//  mul_b      out  5   operand B to core (registered)
//  mul_start  out  1   one-cycle start pulse to core
//  mul_res    in   10  product from core
//  out_res    out  10  captured product (registered)
//  out_valid  out  1   product valid
//  out_ready  in   1   downstream accepts product
//  busy       out  1   state != IDLE
//  done_cnt   out  8   completed-handshake counter, wraps 255->0
// BEHAVIOUR
//  Reset (async, any time, incl. mid-operation): FIFO empty, state IDLE, in_ready=1, mul_start=0, mul_a/b=0,
//   out_res=0, out_valid=0, busy=0, done_cnt=0. Any in-flight op is discarded; no result is emitted for it.
//  FIFO: push when in_valid&in_ready. Pop only on IDLE->ISSUE or HOLD->ISSUE. No bypass: a push into an empty
//   FIFO is not visible to the FSM until the next edge. When full, in_ready=0 and in_valid is ignored.
//   Push and pop in the same cycle leave the count unchanged.
//  FSM states: IDLE, ISSUE, WAIT, HOLD.
//   IDLE : count>0 -> pop head into mul_a/mul_b, go ISSUE; else stay.
//   ISSUE: mul_start=1 for exactly this one cycle; load counter=SETTLE; go WAIT.
//   WAIT : counter decrements each cycle; on the edge where counter==1, out_res<=mul_res, out_valid<=1, go HOLD.
//   HOLD : out_valid=1, out_res stable until out_ready. On out_valid&out_ready: done_cnt++, out_valid<=0;
//          if count>0, pop and go ISSUE in the same edge (back-to-back), else go IDLE.
//  mul_start is high only in ISSUE; never asserted outside ISSUE. mul_a/mul_b change only on a pop.
//  Latency: operand pushed at edge t0 into an empty, idle block -> out_valid high after edge t0+2+SETTLE
//   (t0+14 at default). Throughput: one product per SETTLE+2 cycles with out_ready held high.
//  Width: out_res is the full 10-bit product, no truncation; max 31*31=961.
//  Ordering: results leave in operand-acceptance order; no drops, no duplicates.
//  out_ready while out_valid=0 has no effect; out_valid never drops without a handshake except on reset.
// TESTING
//  T1 single: push (5,7), out_ready=1 -> mul_start one cycle, out_res=35 with out_valid at t0+14, done_cnt=1.
//  T2 corners: push (0,31),(31,0),(31,31),(1,1) -> out_res 0,0,961,1 in order; mul_start exactly 4 pulses.
//  T3 backpressure: out_ready=0 for 40 cycles after first result -> out_res=35 held, no new mul_start, then
//     release -> remaining results follow in order, done_cnt counts only handshakes.
//  T4 full FIFO: out_ready=0, push 6 pairs -> in_ready low after DEPTH FIFO entries + 1 in flight, extra
//     in_valid ignored; release -> exactly 5 results, correct values.
//  T5 reset mid-WAIT: push (9,9), assert irst 5 cycles into WAIT -> all outputs to reset values immediately;
//     after release push (3,4) -> single result 12, no result 81 ever emitted.
//  T6 random: 1000 random pairs, random in_valid/out_ready -> scoreboard a*b matches in order, no mul_start
//     outside ISSUE.

Source files
------------

// File: rtl/trachtenberg_feeder.sv
// Operand FIFO plus issue/settle/hold sequencer in front of the 5x5 multiplier core.
// Latency: push at edge t0 into an idle, empty block gives out_valid after edge t0+2+SETTLE. Backpressure: in_ready drops when the FIFO is full; a result is held until out_ready.
module trachtenberg_feeder #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 12
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic [4:0]  in_a,
    input  logic [4:0]  in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [4:0]  mul_a,
    output logic [4:0]  mul_b,
    output logic        mul_start,
    input  logic [9:0]  mul_res,
    output logic [9:0]  out_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [7:0]  done_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [AW:0] FULL_CNT = AW'(DEPTH) == '0 ? {1'b1, {AW{1'b0}}} : {1'b0, AW'(DEPTH)};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t       r_state;
    logic [9:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]  r_count;
    logic [CW-1:0] r_settle;
    logic [4:0]   r_mul_a;
    logic [4:0]   r_mul_b;
    logic         r_start;
    logic [9:0]   r_out_res;
    logic         r_out_valid;
    logic [7:0]   r_done_cnt;

    logic         w_push;
    logic         w_pop;
    logic         w_nempty;
    logic [9:0]   w_head;

    assign w_nempty = (r_count != '0);
    assign in_ready = (r_count != FULL_CNT);
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rptr];

    // Pop happens only on the transitions into ISSUE; no bypass of a same-cycle push.
    always_comb begin
        w_pop = 1'b0;
        if (w_nempty) begin
            if (r_state == S_IDLE)
                w_pop = 1'b1;
            else if (r_state == S_HOLD && out_ready)
                w_pop = 1'b1;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {in_a, in_b};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_start     <= 1'b0;
            r_out_res   <= '0;
            r_out_valid <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_mul_a <= w_head[9:5];
                        r_mul_b <= w_head[4:0];
                        r_start <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start  <= 1'b0;
                    r_settle <= CW'(SETTLE);
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    r_settle <= r_settle - 1'b1;
                    if (r_settle == CW'(1)) begin
                        r_out_res   <= mul_res;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_done_cnt  <= r_done_cnt + 1'b1;
                        r_out_valid <= 1'b0;
                        if (w_pop) begin
                            r_mul_a <= w_head[9:5];
                            r_mul_b <= w_head[4:0];
                            r_start <= 1'b1;
                            r_state <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_start = r_start;
    assign out_res   = r_out_res;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);
    assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_trachtenberg_feeder.sv
// Directed bench for trachtenberg_feeder with a behavioural multiplier core and an in-order product scoreboard.
module tb_trachtenberg_feeder;

    logic       iclk = 1'b0;
    logic       irst = 1'b1;
    logic [4:0] in_a = '0;
    logic [4:0] in_b = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] mul_a;
    logic [4:0] mul_b;
    logic       mul_start;
    logic [9:0] mul_res;
    logic [9:0] out_res;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic [7:0] done_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;
    bit prev_start = 1'b0;
    bit saw81 = 1'b0;
    logic [9:0] expq [$];
    logic [9:0] got [$];

    trachtenberg_feeder #(.DEPTH(4), .SETTLE(12)) dut (
        .iclk      (iclk),
        .irst      (irst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_res   (mul_res),
        .out_res   (out_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    assign mul_res = {5'd0, mul_a} * {5'd0, mul_b};

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [4:0] b);
        int k;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (k = 0; k < 500 && !in_ready; k++) tick(1);
        check("push_ready", {31'd0, in_ready}, 32'd1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input logic [7:0] tgt, input string tag);
        int k;
        for (k = 0; k < 3000 && done_cnt !== tgt; k++) tick(1);
        check(tag, {24'd0, done_cnt}, {24'd0, tgt});
    endtask

    // Sampled mid-cycle: inputs are stable here, so this sees exactly what the next edge commits.
    always @(negedge iclk) begin
        if (!irst) begin
            if (in_valid && in_ready) begin
                expq.push_back({5'd0, in_a} * {5'd0, in_b});
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                got.push_back(out_res);
                if (out_res == 10'd81) saw81 = 1'b1;
                if (expq.size() == 0)
                    check("sb_unexpected", {22'd0, out_res}, 32'hFFFF_FFFF);
                else
                    check("sb_product", {22'd0, out_res}, {22'd0, expq.pop_front()});
            end
            if (mul_start) begin
                start_cnt++;
                check("start_busy", {31'd0, busy}, 32'd1);
                check("start_single", {31'd0, prev_start}, 32'd0);
            end
            prev_start = mul_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    initial begin
        int lat;
        int s0;
        int a0;
        int g0;
        int cyc;

        // Reset values
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {24'd0, done_cnt}, 32'd0);
        check("rst_start", {31'd0, mul_start}, 32'd0);
        check("rst_mul_a", {27'd0, mul_a}, 32'd0);
        check("rst_out_res", {22'd0, out_res}, 32'd0);
        tick(2);
        irst = 1'b0;
        tick(1);

        // T1 single op latency
        out_ready = 1'b1;
        s0 = start_cnt;
        push(5'd5, 5'd7);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("t1_latency", lat, 32'd14);
        check("t1_res", {22'd0, out_res}, 32'd35);
        tick(1);
        check("t1_valid_drop", {31'd0, out_valid}, 32'd0);
        check("t1_done", {24'd0, done_cnt}, 32'd1);
        check("t1_starts", start_cnt - s0, 32'd1);

        // T2 corner operands
        s0 = start_cnt;
        g0 = got.size();
        push(5'd0, 5'd31);
        push(5'd31, 5'd0);
        push(5'd31, 5'd31);
        push(5'd1, 5'd1);
        wait_done(8'd5, "t2_done");
        check("t2_r0", {22'd0, got[g0]}, 32'd0);
        check("t2_r1", {22'd0, got[g0+1]}, 32'd0);
        check("t2_r2", {22'd0, got[g0+2]}, 32'd961);
        check("t2_r3", {22'd0, got[g0+3]}, 32'd1);
        check("t2_starts", start_cnt - s0, 32'd4);

        // T3 output backpressure
        out_ready = 1'b0;
        g0 = got.size();
        push(5'd5, 5'd7);
        push(5'd2, 5'd3);
        push(5'd4, 5'd6);
        for (int k = 0; k < 100 && !out_valid; k++) tick(1);
        s0 = start_cnt;
        tick(40);
        check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
        check("t3_hold_res", {22'd0, out_res}, 32'd35);
        check("t3_no_start", start_cnt - s0, 32'd0);
        check("t3_done_held", {24'd0, done_cnt}, 32'd5);
        out_ready = 1'b1;
        wait_done(8'd8, "t3_done");
        check("t3_r0", {22'd0, got[g0]}, 32'd35);
        check("t3_r1", {22'd0, got[g0+1]}, 32'd6);
        check("t3_r2", {22'd0, got[g0+2]}, 32'd24);

        // T4 full FIFO: one in flight plus DEPTH buffered
        out_ready = 1'b0;
        a0 = acc_cnt;
        g0 = got.size();
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_a = 5'(2 * k + 1);
            in_b = 5'(2 * k + 2);
            tick(1);
        end
        tick(4);
        check("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        check("t4_accepted", acc_cnt - a0, 32'd5);
        out_ready = 1'b1;
        wait_done(8'd13, "t4_done");
        check("t4_results", got.size() - g0, 32'd5);
        check("t4_r0", {22'd0, got[g0]}, 32'd2);
        check("t4_r2", {22'd0, got[g0+2]}, 32'd30);
        check("t4_r4", {22'd0, got[g0+4]}, 32'd90);
        tick(20);
        check("t4_no_extra", {24'd0, done_cnt}, 32'd13);

        // T5 reset in the middle of WAIT
        saw81 = 1'b0;
        push(5'd9, 5'd9);
        tick(7);
        irst = 1'b1;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_mul_a", {27'd0, mul_a}, 32'd0);
        check("t5_done", {24'd0, done_cnt}, 32'd0);
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_in_ready", {31'd0, in_ready}, 32'd1);
        expq.delete();
        tick(2);
        irst = 1'b0;
        tick(1);
        g0 = got.size();
        push(5'd3, 5'd4);
        wait_done(8'd1, "t5_done_after");
        check("t5_res", {22'd0, got[g0]}, 32'd12);
        tick(30);
        check("t5_no81", {31'd0, saw81}, 32'd0);
        check("t5_single", got.size() - g0, 32'd1);

        // T6 random traffic
        a0 = acc_cnt;
        s0 = hs_cnt;
        cyc = 0;
        while (acc_cnt - a0 < 1000 && cyc < 40000) begin
            if (!(in_valid && in_ready)) begin
                in_a = 5'($urandom_range(0, 31));
                in_b = 5'($urandom_range(0, 31));
            end
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if (acc_cnt - a0 == 999 && in_valid && in_ready) begin
                tick(1);
                in_valid = 1'b0;
            end else begin
                tick(1);
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("t6_accepted", acc_cnt - a0, 32'd1000);
        for (int k = 0; k < 20000 && expq.size() != 0; k++) tick(1);
        tick(2);
        check("t6_drained", expq.size(), 32'd0);
        check("t6_handshakes", hs_cnt - s0, 32'd1000);
        check("t6_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
